// File: rtl/instr_issuer.sv
// Instruction issuer: streams a small program buffer to the CPU over the in/load/s/w handshake.
// Each entry gets a one-cycle load, a one-cycle start, then a bounded wait for w to fall and rise.
module instr_issuer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [15:0]       wr_data_i,
    input  logic              run_i,
    input  logic [ADDR_W:0]   run_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W:0]   issued_o,
    output logic [2:0]        flags_o,
    output logic [15:0]       cpu_in_o,
    output logic              cpu_load_o,
    output logic              cpu_s_o,
    input  logic              cpu_w_i,
    input  logic              cpu_N_i,
    input  logic              cpu_V_i,
    input  logic              cpu_Z_i,
    output logic [2:0]        state_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        FINISH    = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t            state_q;
    logic [15:0]       mem_q [DEPTH];
    logic [CNT_W-1:0]  tmo_q;
    logic [ADDR_W:0]   len_q;
    logic              busy_q, done_q, err_q, load_q, s_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W:0]   issued_q;
    logic [2:0]        flags_q;
    logic [15:0]       cpu_in_q;

    logic [15:0]       first_word;
    logic [ADDR_W-1:0] pc_d;
    logic              last_instr;

    // A write landing on the same edge as run must be visible to the first LOAD.
    assign first_word = (wr_en_i && wr_addr_i == '0) ? wr_data_i : mem_q[0];
    assign pc_d       = pc_q + ADDR_W'(1);
    assign last_instr = ((ADDR_W+1)'(pc_q) + (ADDR_W+1)'(1)) == len_q;

    always_ff @(posedge clk) begin
        if (wr_en_i && state_q == IDLE) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Handshake: cpu_in is stable from LOAD onward; load and s are single-cycle strobes in
    // LOAD and START; the CPU acknowledges by dropping w and completes by raising it again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            s_q      <= 1'b0;
            pc_q     <= '0;
            issued_q <= '0;
            flags_q  <= '0;
            cpu_in_q <= '0;
            tmo_q    <= '0;
            len_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run_i) begin
                        busy_q <= 1'b1;
                        if (run_len_i > (ADDR_W+1)'(DEPTH)) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            err_q    <= 1'b0;
                            issued_q <= '0;
                            pc_q     <= '0;
                            len_q    <= run_len_i;
                            if (run_len_i == '0) begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= LOAD;
                                load_q   <= 1'b1;
                                cpu_in_q <= first_word;
                            end
                        end
                    end
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    s_q     <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    s_q     <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!cpu_w_i) begin
                        tmo_q   <= '0;
                        state_q <= WAIT_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (cpu_w_i) begin
                        flags_q  <= {cpu_N_i, cpu_V_i, cpu_Z_i};
                        issued_q <= issued_q + (ADDR_W+1)'(1);
                        if (last_instr) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            pc_q     <= pc_d;
                            load_q   <= 1'b1;
                            cpu_in_q <= mem_q[pc_d];
                            state_q  <= LOAD;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + CNT_W'(1);
                    end
                end
                FINISH, ERROR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign pc_o       = pc_q;
    assign issued_o   = issued_q;
    assign flags_o    = flags_q;
    assign cpu_in_o   = cpu_in_q;
    assign cpu_load_o = load_q;
    assign cpu_s_o    = s_q;
    assign state_o    = state_q;

endmodule
